// File: rtl/fifocntl_tx_pkg.sv
// fifocntl_tx_pkg: shared widths, word field offsets and FSM state type for the tx FIFO-to-stream controller
package fifocntl_tx_pkg;
  localparam int WORD_W = 1048;
  localparam int BEAT_W = 256;
  localparam int KEEP_W = 32;
  localparam int MAX_BEATS = 4;
  localparam int LEN_LSB = 0;
  localparam int DEST_LSB = 8;
  localparam int DATA_LSB = 24;
  typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;
endpackage

// File: rtl/fifocntl_tx_keepgen.sv
// fifocntl_tx_keepgen: last-beat byte-enable mask, low (i_n+1) bits set
module fifocntl_tx_keepgen
  import fifocntl_tx_pkg::*;
(
  input  logic [4:0]        i_n,
  output logic [KEEP_W-1:0] o_mask
);
  assign o_mask = {KEEP_W{1'b1}} >> (5'd31 - i_n);
endmodule

// File: rtl/fifocntl_tx.sv
// fifocntl_tx: reads one packed frame word from the tx FIFO and replays it as up to four AXI4-stream beats
module fifocntl_tx
  import fifocntl_tx_pkg::*;
(
  input  logic              inclk,
  input  logic              inrst,
  input  logic              txfifoempty,
  output logic              txfifore,
  input  logic [WORD_W-1:0] tx_fifo,
  output logic [BEAT_W-1:0] tdata,
  output logic [KEEP_W-1:0] tkeep,
  output logic [127:0]      tuser,
  output logic              tvalid,
  input  logic              tready,
  output logic              tlast,
  output logic [15:0]       txframes,
  output logic              txerr
);
  state_t r_state, w_next;
  logic [WORD_W-1:0] r_buf;
  logic [$clog2(MAX_BEATS)-1:0] r_idx;
  logic [15:0] r_txframes;
  logic w_bad, w_last, w_hs, w_v;
  logic [KEEP_W-1:0] w_mask;
  logic [BEAT_W-1:0] w_beat;
  // beat count minus one exceeds 3 exactly when the top len bit is set
  assign w_bad = tx_fifo[LEN_LSB+7];
  assign w_last = {1'b0, r_idx} == r_buf[LEN_LSB+5 +: 3];
  assign w_beat = r_buf[DATA_LSB + BEAT_W*r_idx +: BEAT_W];
  assign w_hs = r_state == SEND && tready;
  assign w_v = r_state == SEND && !inrst;
  fifocntl_tx_keepgen u_keepgen (
    .i_n    (r_buf[LEN_LSB +: 5]),
    .o_mask (w_mask)
  );
  always_ff @(posedge inclk) begin
    if (inrst) begin
      r_state <= IDLE;
      r_buf <= '0;
      r_idx <= '0;
      r_txframes <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == FETCH) begin
        r_buf <= tx_fifo;
        r_idx <= '0;
      end else if (w_hs && !w_last) r_idx <= r_idx + 1'b1;
      if (w_hs && w_last) r_txframes <= r_txframes + 16'd1;
    end
  end
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && !txfifoempty) w_next = FETCH;
    if (r_state == FETCH) w_next = w_bad ? IDLE : SEND;
    if (w_hs && w_last) w_next = IDLE;
    txfifore = r_state == IDLE && !txfifoempty && !inrst;
    txerr = r_state == FETCH && w_bad && !inrst;
    tvalid = w_v;
    tlast = w_v && w_last;
    tdata = w_v ? w_beat : '0;
    tkeep = w_v ? (w_last ? w_mask : '1) : '0;
    tuser = w_v ? {96'b0, r_buf[DEST_LSB +: 16], 16'b0} : '0;
    txframes = r_txframes;
  end
endmodule
